// File: rtl/visor_uart_pkg.sv
// Shared definitions for the supervisor UART: receiver FSM states, default bit
// timing and the atx_ctrl status bit layout used by both RTL and ROM program.
package visor_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

  // 50 MHz system clock, 115200 baud
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;

  localparam logic [7:0] ATX_CTRL_ARX_BUSY  = 8'h01;
  localparam logic [7:0] ATX_CTRL_RX_VALID  = 8'h02;
  localparam logic [7:0] ATX_CTRL_RX_OVERUN = 8'h04;
  localparam logic [7:0] ATX_CTRL_RX_FRMERR = 8'h08;

  function automatic logic [7:0] atx_ctrl_pack(input logic busy,
                                               input logic valid,
                                               input logic overrun,
                                               input logic frame_err);
    logic [7:0] v;
    v = 8'h00;
    if (busy)      v = v | ATX_CTRL_ARX_BUSY;
    if (valid)     v = v | ATX_CTRL_RX_VALID;
    if (overrun)   v = v | ATX_CTRL_RX_OVERUN;
    if (frame_err) v = v | ATX_CTRL_RX_FRMERR;
    return v;
  endfunction

endpackage

// File: rtl/visor_byte_fifo.sv
// Byte-wide first-word-fall-through FIFO with a registered head output.
// A push into a full FIFO succeeds when a pop is accepted in the same cycle.
module visor_byte_fifo
  import visor_uart_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push_i,
  input  logic [7:0] push_data_i,
  input  logic       pop_i,
  output logic [7:0] head_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_after_pop;
  logic [7:0]    head_q, head_d;
  logic          do_pop, do_push;

  always_comb begin
    do_pop        = pop_i && (cnt_q != '0);
    do_push       = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);
    rd_d          = do_pop ? rd_q + 1'b1 : rd_q;
    wr_d          = do_push ? wr_q + 1'b1 : wr_q;
    cnt_after_pop = do_pop ? cnt_q - 1'b1 : cnt_q;
    cnt_d         = do_push ? cnt_after_pop + 1'b1 : cnt_after_pop;

    // Head follows the oldest surviving entry; a push into an empty FIFO bypasses storage
    head_d = head_q;
    if (cnt_after_pop != '0) begin
      head_d = mem_q[rd_d];
    end else if (do_push) begin
      head_d = push_data_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      head_q <= 8'h00;
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q] <= push_data_i;
    end
  end

  assign head_o  = head_q;
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/visor_uart_rx.sv
// 8N1 UART receiver for the supervisor MCU: synchronizes rxd, frames characters
// at mid-bit and queues bytes in a FWFT FIFO with sticky overrun/framing flags.
module visor_uart_rx
  import visor_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rxd,
  input  logic       rx_pop,
  input  logic       err_clear,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       rx_overrun,
  output logic       rx_frame_err
);

  localparam logic [15:0] HALF_RELOAD = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL_RELOAD = 16'(CLKS_PER_BIT - 1);

  logic        sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]  sync_vld_q, sync_vld_d;
  logic        line_prev_q, line_prev_d;
  logic        start_q, start_d;
  logic [15:0] timer_q, timer_d;
  logic        tick_q, tick_d;
  logic        sample_q, sample_d;
  rx_state_e   state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        overrun_q, overrun_d;
  logic        frame_err_q, frame_err_d;

  logic        fall, timing_state;
  logic        push_req, frame_set, ovr_set;
  logic        fifo_full, fifo_empty;

  // Line front end. line_prev only holds a genuine pin sample, so a line that
  // is already low when reset releases never looks like a falling edge.
  always_comb begin
    sync1_d      = rxd;
    sync2_d      = sync1_q;
    sync_vld_d   = {sync_vld_q[0], 1'b1};
    line_prev_d  = sync2_q & sync_vld_q[1];
    fall         = line_prev_q & ~sync2_q;
    start_d      = fall && (state_q == ST_IDLE);
    timing_state = (state_q == ST_START) || (state_q == ST_DATA) || (state_q == ST_STOP);
    tick_d       = (timer_q == '0) && timing_state;
    sample_d     = tick_d ? sync2_q : sample_q;

    if (start_d) begin
      timer_d = HALF_RELOAD;
    end else if (tick_d) begin
      timer_d = FULL_RELOAD;
    end else if (timer_q != '0) begin
      timer_d = timer_q - 16'd1;
    end else begin
      timer_d = timer_q;
    end
  end

  // Frame FSM acts one clock after each mid-bit sample, using the captured sample
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    push_req  = 1'b0;
    frame_set = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_q) state_d = ST_START;
      end
      ST_START: begin
        if (tick_q) begin
          if (!sample_q) begin
            state_d   = ST_DATA;
            bit_cnt_d = 3'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (tick_q) begin
          shift_d   = {sample_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick_q) begin
          if (sample_q) begin
            push_req = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            frame_set = 1'b1;
            state_d   = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (sync2_q) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A push into a full FIFO only survives when the same-cycle pop frees a slot
    ovr_set     = push_req & fifo_full & ~rx_pop;
    overrun_d   = ovr_set | (overrun_q & ~err_clear);
    frame_err_d = frame_set | (frame_err_q & ~err_clear);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      sync_vld_q  <= 2'b00;
      line_prev_q <= 1'b0;
      start_q     <= 1'b0;
      timer_q     <= '0;
      tick_q      <= 1'b0;
      sample_q    <= 1'b1;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sync_vld_q  <= sync_vld_d;
      line_prev_q <= line_prev_d;
      start_q     <= start_d;
      timer_q     <= timer_d;
      tick_q      <= tick_d;
      sample_q    <= sample_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  visor_byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .push_i     (push_req),
    .push_data_i(shift_q),
    .pop_i      (rx_pop),
    .head_o     (rx_data),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  assign rx_valid     = ~fifo_empty;
  assign rx_busy      = (state_q != ST_IDLE);
  assign rx_overrun   = overrun_q;
  assign rx_frame_err = frame_err_q;

endmodule
